// File: rtl/fpu_pkg.sv
// Shared single-precision FPU types, constants and pipeline payloads.
package fpu_pkg;

   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [22:0] man;
   } float_t;

   localparam logic [7:0]  EXP_INF      = 8'd255;
   localparam logic [31:0] QNAN_DEFAULT = 32'hFFC00000;

   // b is the subtrahend with its sign already flipped (the effective addend)
   typedef struct packed {
      logic   a_nan;
      logic   b_nan;
      logic   a_inf;
      logic   b_inf;
      logic   zsign;
      float_t a;
      float_t b;
   } spec_t;

   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [26:0] m_big;
      logic [26:0] m_small;
      logic        eff_sub;
      spec_t       sp;
   } s1_t;

   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [26:0] m;
      logic        zero;
      logic        ovf1;
      spec_t       sp;
   } s2_t;

   function automatic logic [23:0] sig24(input float_t f);
      return {f.exp != 8'd0, f.man};
   endfunction

endpackage

// File: rtl/fpu_lzc27.sv
// Combinational 27-bit leading-zero count, 0..27 (27 for an all-zero input).
module fpu_lzc27 (
   input  logic [26:0] a,
   output logic [4:0]  count
);

   // ascending scan: the highest set bit overwrites last
   always_comb begin
      count = 5'd27;
      for (int i = 0; i <= 26; i++) begin
         if (a[i]) count = 5'(26 - i);
      end
   end

endmodule

// File: rtl/fsub_pipe.sv
// Three-stage pipelined single-precision subtractor y = x1 - x2 with valid/ready.
// Define FSUB_FTZ_EN to flush denormal inputs and results to signed zero.
module fsub_pipe
   import fpu_pkg::*;
(
   input  logic        clk,
   input  logic        rstn,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] x1,
   input  logic [31:0] x2,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] y,
   output logic        ovf
);

   logic v1, v2, v3, adv1, adv2, adv3, acc;
   s1_t  s1_d, s1_q;
   s2_t  s2_d, s2_q;

   assign adv3      = v3 & out_ready;
   assign adv2      = v2 & (~v3 | adv3);
   assign adv1      = v1 & (~v2 | adv2);
   assign in_ready  = ~v1 | adv1;
   assign acc       = in_valid & in_ready;
   assign out_valid = v3;

   // S1: align
   float_t      a_op, b_op, a_ar, b_ar;
   logic [7:0]  ea, eb, e_big, e_sml, diff;
   logic [23:0] ma, mb, m_big, m_sml;
   logic [4:0]  sh1;
   logic [55:0] wide;
   logic        a_big;

   always_comb begin
      a_op = x1;
      b_op = {~x2[31], x2[30:0]};
      a_ar = a_op;
      b_ar = b_op;
`ifdef FSUB_FTZ_EN
      if (a_op.exp == 8'd0) a_ar.man = '0;
      if (b_op.exp == 8'd0) b_ar.man = '0;
`endif
      ea    = (a_ar.exp == 8'd0) ? 8'd1 : a_ar.exp;
      eb    = (b_ar.exp == 8'd0) ? 8'd1 : b_ar.exp;
      ma    = sig24(a_ar);
      mb    = sig24(b_ar);
      a_big = {ea, ma} >= {eb, mb};
      e_big = a_big ? ea : eb;
      e_sml = a_big ? eb : ea;
      m_big = a_big ? ma : mb;
      m_sml = a_big ? mb : ma;
      diff  = e_big - e_sml;
      sh1   = (diff > 8'd31) ? 5'd31 : diff[4:0];
      wide  = {m_sml, 32'b0} >> sh1;

      s1_d.sign     = a_big ? a_op.sign : b_op.sign;
      s1_d.exp      = e_big;
      s1_d.m_big    = {m_big, 3'b000};
      s1_d.m_small  = {wide[55:30], wide[29] | (|wide[28:0])};
      s1_d.eff_sub  = a_op.sign ^ b_op.sign;
      s1_d.sp.a_nan = (a_op.exp == EXP_INF) && (a_op.man != '0);
      s1_d.sp.b_nan = (b_op.exp == EXP_INF) && (b_op.man != '0);
      s1_d.sp.a_inf = (a_op.exp == EXP_INF) && (a_op.man == '0);
      s1_d.sp.b_inf = (b_op.exp == EXP_INF) && (b_op.man == '0);
      s1_d.sp.zsign = a_op.sign & b_op.sign;
      s1_d.sp.a     = a_op;
      s1_d.sp.b     = b_op;
   end

   // S2: add / normalize
   logic [27:0] sum;
   logic [4:0]  lz, sh2;
   logic [8:0]  exp_p1;
   logic [7:0]  lim;

   fpu_lzc27 u_lzc (.a(sum[26:0]), .count(lz));

   always_comb begin
      sum    = s1_q.eff_sub ? ({1'b0, s1_q.m_big} - {1'b0, s1_q.m_small})
                            : ({1'b0, s1_q.m_big} + {1'b0, s1_q.m_small});
      exp_p1 = {1'b0, s1_q.exp} + 9'd1;
      lim    = s1_q.exp - 8'd1;
      // lim < 27 whenever it wins, so its low bits are enough
      sh2    = ({3'b0, lz} > lim) ? lim[4:0] : lz;

      s2_d.sign = s1_q.sign;
      s2_d.sp   = s1_q.sp;
      s2_d.zero = (sum == '0);
      s2_d.ovf1 = 1'b0;
      if (sum[27]) begin
         s2_d.m    = {sum[27:2], sum[1] | sum[0]};
         s2_d.exp  = exp_p1[7:0];
         s2_d.ovf1 = (exp_p1 == 9'd255);
      end else begin
         s2_d.m    = sum[26:0] << sh2;
         s2_d.exp  = s1_q.exp - {3'b0, sh2};
      end
   end

   // S3: round / pack / special-case mux
   logic        inc, hidden, ovf2;
   logic [24:0] rnd;
   logic [8:0]  exp_r;
   logic [22:0] mant;
   logic [31:0] y_d;
   logic        ovf_d;
   spec_t       sp3;

   always_comb begin
      sp3    = s2_q.sp;
      inc    = s2_q.m[2] & (s2_q.m[1] | s2_q.m[0] | s2_q.m[3]);
      rnd    = {1'b0, s2_q.m[26:3]} + {24'b0, inc};
      exp_r  = {1'b0, s2_q.exp} + {8'b0, rnd[24]};
      hidden = rnd[24] | rnd[23];
      mant   = rnd[24] ? rnd[23:1] : rnd[22:0];
      ovf2   = rnd[24] & (exp_r == 9'd255);
      y_d    = {s2_q.sign, (hidden ? exp_r[7:0] : 8'd0), mant};

      if (s2_q.zero)      y_d = {sp3.zsign, 31'b0};
      else if (s2_q.ovf1) y_d = {s2_q.sign, EXP_INF, 23'b0};
`ifdef FSUB_FTZ_EN
      if (y_d[30:23] == 8'd0) y_d = {y_d[31], 31'b0};
`endif

      if (sp3.b_nan)                    y_d = {sp3.b[31:23], 1'b1, sp3.b[21:0]};
      else if (sp3.a_nan)               y_d = {sp3.a[31:23], 1'b1, sp3.a[21:0]};
      else if (sp3.a_inf && sp3.b_inf)  y_d = (sp3.a.sign != sp3.b.sign) ? QNAN_DEFAULT
                                                                         : sp3.a;
      else if (sp3.a_inf)               y_d = sp3.a;
      else if (sp3.b_inf)               y_d = sp3.b;

      ovf_d = (s2_q.ovf1 | ovf2) & ~((sp3.a.exp == EXP_INF) | (sp3.b.exp == EXP_INF));
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         v1  <= 1'b0;
         v2  <= 1'b0;
         v3  <= 1'b0;
         y   <= '0;
         ovf <= 1'b0;
      end else begin
         if (acc)       v1 <= 1'b1;
         else if (adv1) v1 <= 1'b0;
         if (adv1)      v2 <= 1'b1;
         else if (adv2) v2 <= 1'b0;
         if (adv2)      v3 <= 1'b1;
         else if (adv3) v3 <= 1'b0;
         if (adv2) begin
            y   <= y_d;
            ovf <= ovf_d;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (acc)  s1_q <= s1_d;
      if (adv1) s2_q <= s2_d;
   end

endmodule

// File: doc/fsub_pipe.md
Name: fsub_pipe

Overview:
- Pipelined IEEE-754 single-precision subtractor: y = x1 - x2. It is the inverse-direction counterpart of the team's combinational fadd.
- Three register stages with valid/ready handshakes on both sides, so the FPU dispatcher can issue one op per cycle and stall on writeback backpressure.
- Numeric results, including NaN/inf/zero-sign rules and the ovf flag, are bit-identical to fadd(x1, {~x2[31], x2[30:0]}).

Parameters:
- none (latency fixed at 3; width fixed at 32)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rstn  in  1  reset; synchronous, active-low
- in_valid  in  1  x1/x2 valid this cycle
- in_ready  out  1  block accepts an op this cycle
- x1  in  32  minuend, IEEE single
- x2  in  32  subtrahend, IEEE single
- out_valid  out  1  y/ovf valid
- out_ready  in  1  consumer takes result this cycle
- y  out  32  x1 - x2, round-to-nearest-even
- ovf  out  1  finite operands produced exponent 255 (either pre-round carry or round carry)

Behaviour:
- Reset: on a clk edge with rstn=0, all stage valid bits clear. Next cycle: out_valid=0, y=0, ovf=0, in_ready=1. Reset mid-flight discards all in-flight ops silently.
- Handshake:
  - Accept when in_valid & in_ready.
  - Output consumed when out_valid & out_ready.
  - y/ovf hold stable while out_valid=1 and out_ready=0.
- Stage advance: stage k advances iff it is valid and stage k+1 is empty or advancing. in_ready = !v1 | adv1, which is combinational from out_ready through the stage chain. No bubbles are inserted when unstalled.
- Latency and throughput: 3 cycles accept-to-out_valid; throughput 1 op/cycle.
- Capacity: 3 ops. With out_ready=0, exactly 3 ops are accepted, then in_ready=0.
- Ordering: results leave in acceptance order; no drops, no duplicates.
- S1 (align):
  - Negate the x2 sign.
  - Denormal exponent reads as 1 and its hidden bit as 0.
  - Operand with the larger exponent (larger mantissa on a tie) becomes "big".
  - Shift amount = min(exp diff, 31).
  - Shift the small mantissa into a 56-bit field; sticky = OR of bits below the 27-bit window.
  - Latch special-case flags: NaN, inf.
- S2 (add/normalize):
  - Effective add or subtract on 27-bit magnitudes.
  - Carry out: shift right 1 and increment exponent. Sticky |= the dropped bit. If the incremented exponent is 255, force inf and set ovf1.
  - 27-bit leading-zero count; left shift limited so the exponent never goes below 1, producing a denormal.
- S3 (round/pack):
  - RNE on guard/round/sticky bits.
  - Mantissa carry increments the exponent; ovf2 if that exponent reaches 255.
  - Zero result has exponent 0 and sign = s1 & ~s2.
  - Apply special-case mux:
    - Single NaN operand: output that operand with the quiet bit set and its effective sign.
    - Both NaN: x2 payload wins.
    - Single inf: output that inf.
    - inf - inf with the same raw signs: 0xFFC00000.
    - inf - inf with opposite raw signs: inf with the sign of x1.
  - ovf = (ovf1 | ovf2) & neither operand has exponent 255.

Optional Feature:
- FSUB_FTZ_EN defined:
  - S1 treats inputs with exponent 0 as zero of the same sign.
  - S3 flushes any result with exponent 0 to signed zero, sign = rounded-result sign.
  - ovf is unaffected.
- Undefined: full denormal support as in Behaviour.

Decomposition:
- Package fpu_pkg holds:
  - typedef float_t packed struct {sign, exp[7:0], man[22:0]}
  - constants EXP_INF=8'd255, QNAN_DEFAULT=32'hFFC00000
  - typedef for the S1->S2 and S2->S3 stage payload structs
- One sub-module is natural: fpu_lzc27, a combinational 27-bit leading-zero count returning 0..27. It is shared later by fadd/fmul pipelines.

Test Plan:
- 0x40400000 - 0x3F800000 (3-1) accepted at cycle t: out_valid at t+3, y=0x40000000, ovf=0.
- Zero sign: 0x3F800000 - 0x3F800000 gives y=0x00000000. 0x80000000 - 0x00000000 gives y=0x80000000.
- Overflow: 0x7F7FFFFF - 0xFF7FFFFF gives y=0x7F800000, ovf=1.
- Infinities: 0x7F800000 - 0x7F800000 gives y=0xFFC00000, ovf=0. 0x7F800000 - 0xFF800000 gives 0x7F800000.
- Denormal: 0x00800000 - 0x00400000 gives 0x00400000 (FTZ build: 0x00800000).
- Backpressure and reset:
  - out_ready=0 for 6 cycles while 5 ops are offered: in_ready drops after the 3rd accept. Releasing out_ready drains results in order with none lost.
  - rstn=0 for one cycle with 2 ops in flight: next cycle out_valid=0, in_ready=1.
